// File: rtl/ext_mem_arbiter.sv
// Two-port arbiter sharing one external DRAM port between icache refill (p0) and dcache refill/write-back (p1).
// Latches the winning request, holds it until mem_ack_i, returns read data, and flags a DRAM that never answers.
module ext_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [1:0]        gnt_o,
    output logic              err_timeout_o
);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                mem_en_q, mem_en_d;
    req_t                req_q, req_d;
    logic [1:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
    logic [WDOG_W-1:0]   wdog_inc;
    logic                pick_p1;

    // On a tie port 1 wins if fixed priority, or if port 0 was granted last.
    assign pick_p1  = p1_enable_i && (!p0_enable_i || (FIXED_PRIO != 0) || !last_q);
    assign wdog_inc = wdog_q + WDOG_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= '0;
            mem_en_q <= 1'b0;
            req_q    <= '0;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            mem_en_q <= mem_en_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        mem_en_d = mem_en_q;
        req_d    = req_q;
        ack_d    = ack_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        wdog_d   = wdog_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (p0_enable_i || p1_enable_i) begin
                    state_d  = ST_BUSY;
                    last_d   = pick_p1;
                    gnt_d    = pick_p1 ? 2'b10 : 2'b01;
                    mem_en_d = 1'b1;
                    wdog_d   = '0;
                    if (pick_p1) begin
                        req_d.write = p1_write_i;
                        req_d.addr  = p1_addr_i;
                        req_d.data  = p1_data_i;
                    end else begin
                        req_d.write = p0_write_i;
                        req_d.addr  = p0_addr_i;
                        req_d.data  = p0_data_i;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_d     = ST_RESP;
                    mem_en_d    = 1'b0;
                    req_d.write = 1'b0;
                    if (gnt_q[1]) begin
                        rdata1_d = mem_data_i;
                        ack_d    = 2'b10;
                    end else begin
                        rdata0_d = mem_data_i;
                        ack_d    = 2'b01;
                    end
                end else if (wdog_q != WDOG_W'(TIMEOUT)) begin
                    // Saturating count; the transaction keeps waiting after the flag sets.
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDOG_W'(TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ack_d   = '0;
                gnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign p0_ack_o      = ack_q[0];
    assign p1_ack_o      = ack_q[1];
    assign p0_data_o     = rdata0_q;
    assign p1_data_o     = rdata1_q;
    assign mem_enable_o  = mem_en_q;
    assign mem_write_o   = req_q.write;
    assign mem_addr_o    = req_q.addr;
    assign mem_data_o    = req_q.data;
    assign gnt_o         = gnt_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: round-robin instance with a short watchdog, plus a fixed-priority instance.
module tb_ext_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         p0_en = 1'b0, p0_wr = 1'b0, p1_en = 1'b0, p1_wr = 1'b0;
    logic [31:0]  p0_addr = '0, p1_addr = '0;
    logic [255:0] p0_wdata = '0, p1_wdata = '0;
    logic         p0_ack, p1_ack, mem_en, mem_wr, err;
    logic [255:0] p0_rdata, p1_rdata, mem_wdata;
    logic [31:0]  mem_addr;
    logic [1:0]   gnt;
    logic         md_ack_r = 1'b0, md_force = 1'b0, mem_ack;
    logic [255:0] mem_rdata = '0;
    int           md_delay = 2, md_cnt = 0;
    bit           md_never = 1'b0;

    logic         fp_p0_en = 1'b0, fp_p1_en = 1'b0, fp_ack_r = 1'b0;
    logic         fp_p0_ack, fp_p1_ack, fp_mem_en, fp_mem_wr, fp_err;
    logic [255:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
    logic [31:0]  fp_mem_addr;
    logic [1:0]   fp_gnt;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] rd_single;

    always #5 clk = ~clk;

    assign mem_ack = md_ack_r | md_force;

    ext_mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(16), .FIXED_PRIO(0)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_enable_i(p0_en), .p0_write_i(p0_wr), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
        .p0_ack_o(p0_ack), .p0_data_o(p0_rdata),
        .p1_enable_i(p1_en), .p1_write_i(p1_wr), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_ack_o(p1_ack), .p1_data_o(p1_rdata),
        .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_data_i(mem_rdata), .gnt_o(gnt), .err_timeout_o(err)
    );

    ext_mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(64), .FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .rst_i(rst_n),
        .p0_enable_i(fp_p0_en), .p0_write_i(1'b0), .p0_addr_i(32'h0000_0010), .p0_data_i(256'h0),
        .p0_ack_o(fp_p0_ack), .p0_data_o(fp_p0_rdata),
        .p1_enable_i(fp_p1_en), .p1_write_i(1'b0), .p1_addr_i(32'h0000_0020), .p1_data_i(256'h0),
        .p1_ack_o(fp_p1_ack), .p1_data_o(fp_p1_rdata),
        .mem_enable_o(fp_mem_en), .mem_write_o(fp_mem_wr), .mem_addr_o(fp_mem_addr), .mem_data_o(fp_mem_wdata),
        .mem_ack_i(fp_ack_r), .mem_data_i(256'h55), .gnt_o(fp_gnt), .err_timeout_o(fp_err)
    );

    // DRAM model: acks after md_delay+1 cycles of chip select, never while md_never is set.
    always @(negedge clk) begin
        if (md_ack_r) begin
            md_ack_r = 1'b0;
            md_cnt   = 0;
        end else if (mem_en) begin
            if (!md_never && md_cnt >= md_delay) md_ack_r = 1'b1;
            else md_cnt++;
        end else begin
            md_cnt = 0;
        end
    end

    // Second DRAM model for the fixed-priority instance: one-cycle latency.
    always @(negedge clk) begin
        if (fp_ack_r) fp_ack_r = 1'b0;
        else if (fp_mem_en) fp_ack_r = 1'b1;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        p0_en = 1'b0; p1_en = 1'b0; fp_p0_en = 1'b0; fp_p1_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if ({mem_en, mem_wr, gnt, p0_ack, p1_ack, err} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b exp 0000000", {mem_en, mem_wr, gnt, p0_ack, p1_ack, err});
        end
        n_vec++; if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== '0) begin
            n_err++; $display("FAIL reset_data: addr %h wdata %h exp all zero", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        int en_cyc = 0, ack_cyc = 0, wr_seen = 0, t = 0;
        rd_single = {8{32'hCAFE_00AB}};
        mem_rdata = rd_single;
        md_delay = 10; md_never = 1'b0;
        @(negedge clk);
        p0_en = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0040;
        @(negedge clk);
        n_vec++; if ({mem_en, gnt, mem_addr} !== {1'b1, 2'b01, 32'h0000_0040}) begin
            n_err++; $display("FAIL read_grant: en %b gnt %b addr %h exp 1 01 00000040", mem_en, gnt, mem_addr);
        end
        for (t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            if (mem_en) en_cyc++;
            if (mem_wr) wr_seen++;
            if (p0_ack) begin
                ack_cyc++;
                p0_en = 1'b0;
                n_vec++; if (p0_rdata !== rd_single) begin
                    n_err++; $display("FAIL read_data: got %h exp %h", p0_rdata, rd_single);
                end
            end
        end
        n_vec++; if (en_cyc !== 11) begin
            n_err++; $display("FAIL read_en_cycles: got %0d exp 11", en_cyc);
        end
        n_vec++; if (ack_cyc !== 1 || wr_seen !== 0) begin
            n_err++; $display("FAIL read_ack_pulse: ack %0d wr %0d exp 1 0", ack_cyc, wr_seen);
        end
        n_vec++; if ({gnt, p1_ack} !== 3'b000) begin
            n_err++; $display("FAIL read_idle_after: gnt %b p1_ack %b exp 00 0", gnt, p1_ack);
        end
    endtask

    task automatic test_write_back();
        int ack_cyc = 0, unstable = 0;
        md_delay = 4;
        mem_rdata = 256'h1234;
        @(negedge clk);
        p1_en = 1'b1; p1_wr = 1'b1; p1_addr = 32'h0000_0400; p1_wdata = 256'h5;
        @(negedge clk);
        n_vec++; if ({mem_en, mem_wr, gnt, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'b10, 32'h0000_0400, 256'h5}) begin
            n_err++; $display("FAIL wb_grant: en %b wr %b gnt %b addr %h data %h", mem_en, mem_wr, gnt, mem_addr, mem_wdata);
        end
        p1_wdata = 256'h7; p1_addr = 32'h0000_0999; p1_wr = 1'b0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (mem_en && ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0400, 256'h5})) unstable++;
            if (p1_ack) begin
                ack_cyc++;
                p1_en = 1'b0;
            end
        end
        n_vec++; if (unstable !== 0) begin
            n_err++; $display("FAIL wb_stable: got %0d unstable cycles exp 0", unstable);
        end
        n_vec++; if (ack_cyc !== 1 || p0_ack !== 1'b0) begin
            n_err++; $display("FAIL wb_ack: got %0d pulses exp 1", ack_cyc);
        end
        n_vec++; if (p1_rdata !== 256'h1234) begin
            n_err++; $display("FAIL wb_rdata: got %h exp 1234", p1_rdata);
        end
    endtask

    task automatic test_ack_outside_busy();
        @(negedge clk);
        md_force = 1'b1;
        @(negedge clk);
        md_force = 1'b0;
        @(negedge clk);
        n_vec++; if ({mem_en, gnt, p0_ack, p1_ack} !== 5'b0) begin
            n_err++; $display("FAIL stray_ack: got %b exp 00000", {mem_en, gnt, p0_ack, p1_ack});
        end
        n_vec++; if (p0_rdata !== rd_single) begin
            n_err++; $display("FAIL rdata_hold: got %h exp %h", p0_rdata, rd_single);
        end
    endtask

    task automatic test_round_robin();
        int order[4];
        int tick_at[4];
        int k = 0, t = 0;
        apply_reset();
        md_delay = 2;
        p0_en = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0100;
        p1_en = 1'b1; p1_wr = 1'b0; p1_addr = 32'h0000_0200;
        while (k < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (k > 0 && t == tick_at[k-1] + 1) begin
                n_vec++; if ({gnt, mem_en} !== 3'b000) begin
                    n_err++; $display("FAIL rr_idle_gap: gnt %b en %b exp 00 0", gnt, mem_en);
                end
            end
            if (p0_ack || p1_ack) begin
                order[k]   = p1_ack ? 1 : 0;
                tick_at[k] = t;
                n_vec++; if ((p0_ack && p1_ack) || gnt !== (p1_ack ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL rr_ack_gnt: acks %b%b gnt %b", p1_ack, p0_ack, gnt);
                end
                k++;
            end
        end
        p0_en = 1'b0; p1_en = 1'b0;
        n_vec++; if (k !== 4) begin
            n_err++; $display("FAIL rr_timeout: got %0d acks exp 4", k);
        end
        for (int i = 0; i < k; i++) begin
            n_vec++; if (order[i] !== (i % 2)) begin
                n_err++; $display("FAIL rr_order[%0d]: got port %0d exp port %0d", i, order[i], i % 2);
            end
            if (i > 0) begin
                n_vec++; if (tick_at[i] - tick_at[i-1] !== 5) begin
                    n_err++; $display("FAIL rr_spacing[%0d]: got %0d exp 5", i, tick_at[i] - tick_at[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        int exp_order[4] = '{1, 1, 1, 0};
        int k = 0, t = 0;
        fp_p0_en = 1'b1; fp_p1_en = 1'b1;
        while (k < 4 && t < 200) begin
            @(negedge clk);
            t++;
            if (fp_p0_ack || fp_p1_ack) begin
                n_vec++; if ((fp_p1_ack ? 1 : 0) !== exp_order[k]) begin
                    n_err++; $display("FAIL fp_order[%0d]: got port %0d exp port %0d", k, fp_p1_ack ? 1 : 0, exp_order[k]);
                end
                k++;
                if (k == 3) fp_p1_en = 1'b0;
                if (k == 4) fp_p0_en = 1'b0;
            end
        end
        fp_p0_en = 1'b0; fp_p1_en = 1'b0;
        n_vec++; if (k !== 4) begin
            n_err++; $display("FAIL fp_timeout: got %0d acks exp 4", k);
        end
    endtask

    task automatic test_watchdog();
        bit got_ack = 1'b0;
        apply_reset();
        md_never = 1'b1; md_delay = 2;
        mem_rdata = 256'hBEEF;
        p0_en = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_0080;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_vec++; if (mem_en !== 1'b1) begin
                    n_err++; $display("FAIL wd_busy: en %b exp 1", mem_en);
                end
            end
            if (k == 16) begin
                n_vec++; if (err !== 1'b0) begin
                    n_err++; $display("FAIL wd_early: err %b exp 0 at busy cycle 16", err);
                end
            end
            if (k == 17) begin
                n_vec++; if (err !== 1'b1) begin
                    n_err++; $display("FAIL wd_set: err %b exp 1 at busy cycle 17", err);
                end
            end
        end
        repeat (10) @(negedge clk);
        n_vec++; if ({err, mem_en, gnt} !== 4'b1101) begin
            n_err++; $display("FAIL wd_hold: err %b en %b gnt %b exp 1 1 01", err, mem_en, gnt);
        end
        md_never = 1'b0;
        for (int t = 0; t < 10 && !got_ack; t++) begin
            @(negedge clk);
            if (p0_ack) got_ack = 1'b1;
        end
        p0_en = 1'b0;
        n_vec++; if (!got_ack || p0_rdata !== 256'hBEEF) begin
            n_err++; $display("FAIL wd_late_ack: ack %b data %h exp 1 beef", got_ack, p0_rdata);
        end
        @(negedge clk);
        n_vec++; if (err !== 1'b1) begin
            n_err++; $display("FAIL wd_sticky: err %b exp 1", err);
        end
    endtask

    task automatic test_reset_mid_busy();
        int stray = 0;
        repeat (2) @(negedge clk);
        md_delay = 20; md_never = 1'b0;
        p0_en = 1'b1; p0_wr = 1'b0; p0_addr = 32'h0000_00C0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        p0_en = 1'b0;
        #1;
        n_vec++; if ({mem_en, gnt, p0_ack, p1_ack, err} !== 6'b0 || mem_addr !== '0 || p0_rdata !== '0) begin
            n_err++; $display("FAIL mid_reset: en %b gnt %b ack %b%b err %b addr %h", mem_en, gnt, p1_ack, p0_ack, err, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (p0_ack || p1_ack || mem_en || gnt != 2'b00) stray++;
        end
        n_vec++; if (stray !== 0) begin
            n_err++; $display("FAIL post_reset_stray: got %0d active cycles exp 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_back();
        test_ack_outside_busy();
        test_round_robin();
        test_fixed_prio();
        test_watchdog();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
